// File: rtl/banked_ram.sv
// Banked word-addressed RAM with byte-enable writes, an address-error response and
// a zero-fill pass after every reset. One request/response pair per cycle.
module banked_ram #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int NUM_BANKS = 8,
    parameter int DEPTH     = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int BYTES = DATA_W / 8;
    localparam int BIW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
    // a response, once valid, holds its payload until rsp_ready is seen high.
    typedef enum logic [1:0] {INIT, RUN, STALL} state_t;

    state_t             state;
    logic [WIW-1:0]     init_idx;
    logic [DATA_W-1:0]  mem [NUM_BANKS][DEPTH];

    logic [7:0]         bank;
    logic [ADDR_W-9:0]  word;
    logic [BIW-1:0]     bank_idx;
    logic [WIW-1:0]     word_idx;
    logic               addr_err;
    logic               accept;

    assign bank     = req_addr[ADDR_W-1:ADDR_W-8];
    assign word     = req_addr[ADDR_W-9:0];
    assign bank_idx = bank[BIW-1:0];
    assign word_idx = word[WIW-1:0];
    // Widened compares so NUM_BANKS=256 and DEPTH=2^(ADDR_W-8) stay representable.
    assign addr_err = ({1'b0, bank} >= 9'(NUM_BANKS)) ||
                      ({1'b0, word} >= (ADDR_W-7)'(DEPTH));

    assign req_ready = init_done & (~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;

    // Storage has no reset; the INIT pass is what clears it.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem[b][init_idx] <= '0;
            end
        end else if (accept && req_we && !addr_err) begin
            for (int k = 0; k < BYTES; k++) begin
                if (req_be[k]) begin
                    mem[bank_idx][word_idx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_idx  <= '0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == WIW'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= addr_err;
                        rsp_rdata <= (!req_we && !addr_err) ? mem[bank_idx][word_idx] : '0;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                    state <= (rsp_valid && !rsp_ready) ? STALL : RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banked_ram.sv
// Randomized and directed checks of banked_ram against an address-keyed reference memory.
module tb_banked_ram;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  banked_ram dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit model_init = 0;

  logic [32:0] exp_q[$];               // {err, rdata} of the outstanding response
  logic [31:0] ref_mem[logic [31:0]];  // keyed by full valid address, absent = 0

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] a);
    return (a[31:24] >= 8'd8) || (a[23:0] >= 24'd256);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic cycle(input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input bit rr);
    bit exp_rdy;
    logic [31:0] old;
    if (exp_q.size() != 0) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_payload", {rsp_err, rsp_rdata}, exp_q[0]);
    end else begin
      check("rsp_idle", rsp_valid, 0);
    end
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_be = be; rsp_ready = rr;
    #1;
    exp_rdy = model_init && (exp_q.size() == 0 || rr);
    check("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
    if (v && exp_rdy) begin
      if (ref_err(a)) begin
        exp_q.push_back({1'b1, 32'h0});
      end else if (we) begin
        old = ref_read(a);
        for (int k = 0; k < 4; k++) if (be[k]) old[8*k +: 8] = wd[8*k +: 8];
        ref_mem[a] = old;
        exp_q.push_back({1'b0, 32'h0});
      end else begin
        exp_q.push_back({1'b0, ref_read(a)});
      end
    end
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1, 0, a, $urandom, $urandom_range(0, 15), 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cycle(1, 1, a, d, be, 1);
  endtask

  // Hold reset a few cycles, release, then count edges until init_done with req_valid high.
  task automatic do_reset(input string tag, input int expect_cycles);
    int cnt;
    rst_n = 1'b0;
    model_init = 0;
    exp_q.delete();
    ref_mem.delete();
    repeat (3) @(negedge clk);
    check({tag, "_rst_outs"}, {req_ready, rsp_valid, rsp_rdata, rsp_err, init_done}, 0);
    req_valid = 1; req_we = 1; req_addr = 32'h0000_0001; req_wdata = 32'hFFFF_FFFF;
    req_be = 4'hF; rsp_ready = 1;
    rst_n = 1'b1;
    cnt = 0;
    while (cnt < 1000) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (init_done) break;
      if (req_ready || rsp_valid) begin
        check({tag, "_early_ready"}, {req_ready, rsp_valid}, 0);
      end
    end
    check({tag, "_init_cycles"}, cnt, expect_cycles);
    check({tag, "_ready_after_init"}, req_ready, 1);
    check({tag, "_no_rsp_after_init"}, rsp_valid, 0);
    req_valid = 0;
    model_init = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return {8'($urandom_range(8, 255)), 24'($urandom_range(0, 255))};
    if (sel == 1) return {8'($urandom_range(0, 7)), 24'($urandom_range(256, 4096))};
    return {8'($urandom_range(0, 7)), 24'($urandom_range(0, 7))};
  endfunction

  initial begin
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    rsp_ready = 1;
    @(negedge clk);
    do_reset("por", 256);

    rd(32'h0300_0010);
    wr(32'h0200_0004, 32'hDEAD_BEEF, 4'b0101);
    rd(32'h0200_0004);
    cycle(0, 0, 0, 0, 0, 1);
    // explicit constant check of the merged word
    wr(32'h0200_0004, 32'hDEAD_BEEF, 4'b0101);
    rd(32'h0200_0004);
    check("merge_value", {rsp_err, rsp_rdata}, {1'b0, 32'h00AD_00EF});
    cycle(0, 0, 0, 0, 0, 1);

    // out-of-range bank/word must not alias onto bank 0 word 0
    wr(32'h0000_0000, 32'h1234_5678, 4'hF);
    rd(32'h0800_0000);
    rd(32'h0000_0100);
    wr(32'h0800_0000, 32'hCAFE_F00D, 4'hF);
    wr(32'h0000_0100, 32'hCAFE_F00D, 4'hF);
    rd(32'h0000_0000);
    cycle(0, 0, 0, 0, 0, 1);

    // response backpressure for 3 cycles with req_valid held
    cycle(1, 0, 32'h0200_0004, 0, 0, 0);
    cycle(1, 0, 32'h0000_0000, 0, 0, 0);
    cycle(1, 0, 32'h0000_0000, 0, 0, 0);
    cycle(1, 0, 32'h0000_0000, 0, 0, 0);
    cycle(1, 0, 32'h0000_0000, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), rand_addr(), $urandom,
            $urandom_range(0, 15), $urandom_range(0, 3) != 0);
    end
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // reset with a response pending, then again at init index 100
    wr(32'h0200_0004, 32'hA5A5_A5A5, 4'hF);
    rst_n = 0;
    exp_q.delete();
    #1;
    check("rst_drops_rsp", {rsp_valid, req_ready, init_done}, 0);
    @(negedge clk);
    req_valid = 1; rsp_ready = 1;
    rst_n = 1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("mid_init_not_done", init_done, 0);
    do_reset("reinit", 256);
    rd(32'h0200_0004);
    check("wiped_word", {rsp_err, rsp_rdata}, 0);
    rd(32'h0000_0000);
    cycle(0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/banked_ram.md
BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits; legal values are multiples of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning request address width.
REQ-003 The block SHALL have parameter NUM_BANKS, default 8, meaning bank count; legal range is 1..256.
REQ-004 The block SHALL have parameter DEPTH, default 256, meaning words per bank; legal values are powers of 2 up to 2^(ADDR_W-8).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit, meaning a request is present.
REQ-008 The block SHALL have port req_ready, output, 1 bit, meaning the block can accept a request this cycle.
REQ-009 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, ADDR_W bits, the word address.
REQ-011 The block SHALL have port req_wdata, input, DATA_W bits, the write data.
REQ-012 The block SHALL have port req_be, input, DATA_W/8 bits, the write byte enables.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit, meaning a response is present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit, meaning the consumer accepts the response.
REQ-015 The block SHALL have port rsp_rdata, output, DATA_W bits, the read data.
REQ-016 The block SHALL have port rsp_err, output, 1 bit, the address-error flag.
REQ-017 The block SHALL have port init_done, output, 1 bit, meaning memory zero-fill is complete.

Function
REQ-018 The block SHALL decode bank = req_addr[ADDR_W-1:ADDR_W-8] and word = req_addr[ADDR_W-9:0].
REQ-019 The block SHALL flag an access as an error when bank >= NUM_BANKS or word >= DEPTH.
REQ-020 The block SHALL implement the states INIT, RUN and STALL.
REQ-021 In INIT, the block SHALL write zero to word index i of all banks in parallel, one index per cycle, i = 0..DEPTH-1.
REQ-022 The block SHALL go from INIT to RUN after index DEPTH-1 is written, and SHALL assert init_done from then until reset.
REQ-023 The block SHALL assert req_ready = init_done AND (NOT rsp_valid OR rsp_ready).
REQ-024 The block SHALL ignore req_valid while req_ready is low; no memory update and no response.
REQ-025 A request SHALL be accepted when req_valid AND req_ready at a rising edge; its response SHALL appear with rsp_valid high in the next cycle.
REQ-026 On an accepted write without error, the block SHALL update only the bytes whose req_be bit is 1; it SHALL return rsp_rdata = 0 and rsp_err = 0.
REQ-027 On an accepted read without error, the block SHALL return the stored word in rsp_rdata with rsp_err = 0.
REQ-028 On an accepted request with error, the block SHALL leave memory unchanged and return rsp_rdata = 0, rsp_err = 1.
REQ-029 The block SHALL enter STALL when rsp_valid = 1 and rsp_ready = 0.
REQ-030 In STALL, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready = 1.
REQ-031 When rsp_ready = 1 and a new request is accepted in the same cycle, the new response SHALL replace the old one with no bubble; full throughput is one access per cycle.
REQ-032 A read following a write to the same address in the next cycle SHALL return the newly written data.
REQ-033 When rsp_ready = 1 and no new request is accepted, rsp_valid SHALL deassert in the next cycle.

Reset
REQ-034 While rst_n = 0, the block SHALL force req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0, state = INIT and init index = 0.
REQ-035 An rst_n assertion mid-INIT or mid-RUN SHALL abort all activity, drop any pending response, and restart zero-fill from index 0 after release.
REQ-036 Zero-fill SHALL complete exactly DEPTH cycles after rst_n deasserts.

Verification
REQ-037 Default parameters, release reset, req_valid held at 1 -> init_done and req_ready rise exactly 256 cycles later; no request accepted before that.
REQ-038 After init, read address 0x0300_0010 -> rsp_valid one cycle later with rsp_rdata = 0, rsp_err = 0.
REQ-039 Write 0xDEADBEEF with be = 4'b0101 to 0x0200_0004, then read it back-to-back -> rsp_rdata = 0x00AD00EF.
REQ-040 Read 0x0800_0000 (bank 8) and read 0x0000_0100 (word 256) -> rsp_err = 1, rsp_rdata = 0 for both; a write to 0x0800_0000 leaves memory unchanged.
REQ-041 Hold rsp_ready = 0 for 3 cycles with req_valid = 1 -> req_ready = 0 and the response holds stable; on release, the next request is accepted in the same cycle.
REQ-042 Assert rst_n = 0 at init index 100, then release -> init_done rises 256 cycles after release, and the previously written word reads back as 0.
